// File: rtl/irq_req_capture.sv
// Request capture front end for the 4-to-2 priority encoder: synchronises four async
// request lines, latches events as pending bits and drives the masked encoder inputs.
module irq_req_capture #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_in,
    input  logic [3:0] mask,
    input  logic       ack,
    input  logic [1:0] ack_idx,
    input  logic       ovf_clr,
    output logic       a0,
    output logic       a1,
    output logic       a2,
    output logic       a3,
    output logic [3:0] pending,
    output logic [3:0] overflow,
    output logic       ack_err
);
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0] s;
    logic [3:0] s_d;
    logic [3:0] set_term;
    logic [3:0] clr_term;
    logic [3:0] ovf_new;
    logic [3:0] enc_in;

    // Synchroniser chain plus one-cycle history of its output for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_d    <= '0;
        end else begin
            sync_q[0] <= req_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            s_d <= s;
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        set_term = EDGE_MODE ? (s & ~s_d) : s;
        clr_term = ack ? (4'b0001 << ack_idx) : 4'b0000;
        // An event that lands while its bit is still pending and not being acked is lost.
        ovf_new  = set_term & pending & ~clr_term;
    end

    // Set wins over clear so a fresh event coinciding with its own ack is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            overflow <= '0;
            ack_err  <= 1'b0;
        end else begin
            pending  <= (pending & ~clr_term) | set_term;
            overflow <= (overflow & ~{4{ovf_clr}}) | ovf_new;
            ack_err  <= ack & ~pending[ack_idx];
        end
    end

    assign enc_in = pending & ~mask;
    assign a0 = enc_in[0];
    assign a1 = enc_in[1];
    assign a2 = enc_in[2];
    assign a3 = enc_in[3];
endmodule

// File: tb/tb_irq_req_capture.sv
// Scoreboard bench for irq_req_capture: an edge-mode and a level-mode instance share
// stimulus and are checked against a cycle-level reference model of the capture rules.
module tb_irq_req_capture;
    localparam int SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_in = '0;
    logic [3:0] mask = '0;
    logic       ack = 1'b0;
    logic [1:0] ack_idx = '0;
    logic       ovf_clr = 1'b0;

    logic       e_a0, e_a1, e_a2, e_a3, e_err;
    logic [3:0] e_pend, e_ovf, e_a;
    logic       l_a0, l_a1, l_a2, l_a3, l_err;
    logic [3:0] l_pend, l_ovf, l_a;

    assign e_a = {e_a3, e_a2, e_a1, e_a0};
    assign l_a = {l_a3, l_a2, l_a1, l_a0};

    irq_req_capture #(.SYNC_STAGES(SYNC_STAGES), .EDGE_MODE(1'b1)) dut_e (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask), .ack(ack),
        .ack_idx(ack_idx), .ovf_clr(ovf_clr), .a0(e_a0), .a1(e_a1), .a2(e_a2),
        .a3(e_a3), .pending(e_pend), .overflow(e_ovf), .ack_err(e_err));

    irq_req_capture #(.SYNC_STAGES(SYNC_STAGES), .EDGE_MODE(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask), .ack(ack),
        .ack_idx(ack_idx), .ovf_clr(ovf_clr), .a0(l_a0), .a1(l_a1), .a2(l_a2),
        .a3(l_a3), .pending(l_pend), .overflow(l_ovf), .ack_err(l_err));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pend_e, ovf_e, a_e;
        logic [3:0] pend_l, ovf_l, a_l;
        logic       err_e, err_l;
    } exp_t;

    typedef struct {
        logic [3:0] a_e, a_l;
    } comb_t;

    exp_t  exp_q[$];
    comb_t comb_q[$];

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 = level mode, 1 = edge mode.
    logic [3:0] m_pend [2];
    logic [3:0] m_ovf  [2];
    logic       m_err  [2];
    logic [3:0] hist[$];   // hist[j] = req_in sampled j+1 edges ago

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m] = '0;
            m_ovf[m]  = '0;
            m_err[m]  = 1'b0;
        end
        hist = {};
        for (int j = 0; j <= SYNC_STAGES; j++) hist.push_back(4'b0000);
    endtask

    task automatic model_step(input logic [3:0] r, input logic a, input logic [1:0] ai,
                              input logic oc);
        logic [3:0] seen, seen_prev;
        seen      = hist[SYNC_STAGES-1];
        seen_prev = hist[SYNC_STAGES];
        for (int m = 0; m < 2; m++) begin
            logic [3:0] p_old;
            p_old = m_pend[m];
            m_err[m] = a && !p_old[ai];
            if (oc) m_ovf[m] = 4'b0000;
            for (int i = 0; i < 4; i++) begin
                bit event_now, acked;
                event_now = (m == 1) ? (seen[i] && !seen_prev[i]) : seen[i];
                acked     = a && (int'(ai) == i);
                if (event_now) begin
                    if (p_old[i] && !acked) m_ovf[m][i] = 1'b1;
                    m_pend[m][i] = 1'b1;
                end else if (acked) begin
                    m_pend[m][i] = 1'b0;
                end
            end
        end
        hist.push_front(r);
        void'(hist.pop_back());
    endtask

    // One clock of stimulus: drive at negedge, queue the expected responses.
    task automatic drive(input logic [3:0] r, input logic [3:0] m, input logic a,
                         input logic [1:0] ai, input logic oc);
        comb_t c;
        exp_t  e;
        @(negedge clk);
        req_in = r; mask = m; ack = a; ack_idx = ai; ovf_clr = oc;
        c.a_e = m_pend[1] & ~m;
        c.a_l = m_pend[0] & ~m;
        comb_q.push_back(c);
        model_step(r, a, ai, oc);
        e.pend_e = m_pend[1]; e.ovf_e = m_ovf[1]; e.err_e = m_err[1]; e.a_e = m_pend[1] & ~m;
        e.pend_l = m_pend[0]; e.ovf_l = m_ovf[0]; e.err_l = m_err[0]; e.a_l = m_pend[0] & ~m;
        exp_q.push_back(e);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Asynchronous reset mid-cycle, held for a few clocks while req_in toggles.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        ack = 1'b0; ovf_clr = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({tag, "_async_e"}, {e_pend, e_ovf, e_a, 3'b000, e_err}, 32'h0);
        chk({tag, "_async_l"}, {l_pend, l_ovf, l_a, 3'b000, l_err}, 32'h0);
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            req_in = 4'($urandom);
            @(posedge clk);
            #1;
            chk({tag, "_held_e"}, {e_pend, e_ovf, e_a, 3'b000, e_err}, 32'h0);
            chk({tag, "_held_l"}, {l_pend, l_ovf, l_a, 3'b000, l_err}, 32'h0);
        end
        @(negedge clk);
        req_in = 4'b0000;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Monitor for registered outputs, one sample per clock just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_edge_mode", {e_pend, e_ovf, e_a, 3'b000, e_err},
                    {e.pend_e, e.ovf_e, e.a_e, 3'b000, e.err_e});
                chk("sb_level_mode", {l_pend, l_ovf, l_a, 3'b000, l_err},
                    {e.pend_l, e.ovf_l, e.a_l, 3'b000, e.err_l});
            end
        end
    end

    // Monitor for the combinational encoder inputs right after mask changes.
    initial begin
        comb_t c;
        forever begin
            @(negedge clk);
            #2;
            if (comb_q.size() > 0) begin
                c = comb_q.pop_front();
                chk("sb_comb_a", {l_a, e_a}, {c.a_l, c.a_e});
            end
        end
    end

    initial begin
        model_reset();
        #12;
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // T1: pending = 1010, then async reset clears everything.
        drive(4'b1010, 4'b0000, 1'b0, 2'd0, 1'b0);
        drive(4'b1010, 4'b0000, 1'b0, 2'd0, 1'b0);
        drive(4'b1010, 4'b0000, 1'b0, 2'd0, 1'b0);
        after_edge();
        chk("t1_pend_1010", e_pend, 4'b1010);
        do_reset("t1_rst");

        // T2: three-edge latency then ack clears without error.
        drive(4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0);
        drive(4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0);
        after_edge();
        chk("t2_not_yet", e_pend, 4'b0000);
        drive(4'b0100, 4'b0000, 1'b0, 2'd0, 1'b0);
        after_edge();
        chk("t2_latency", {e_pend, 3'b000, e_a2}, {4'b0100, 4'b0001});
        drive(4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0);
        after_edge();
        chk("t2_ack_clear", {e_pend, 3'b000, e_err}, {4'b0000, 4'b0000});
        do_reset("t2_rst");

        // T3: mask gating is combinational; acking a masked pending bit clears it.
        drive(4'b1001, 4'b0000, 1'b0, 2'd0, 1'b0);
        drive(4'b1001, 4'b0000, 1'b0, 2'd0, 1'b0);
        drive(4'b1001, 4'b0000, 1'b0, 2'd0, 1'b0);
        drive(4'b1001, 4'b1000, 1'b0, 2'd0, 1'b0);
        #1;
        chk("t3_masked_a", e_a, 4'b0001);
        drive(4'b1001, 4'b0000, 1'b0, 2'd0, 1'b0);
        #1;
        chk("t3_unmasked_a", e_a, 4'b1001);
        drive(4'b1001, 4'b1000, 1'b1, 2'd3, 1'b0);
        after_edge();
        chk("t3_ack_masked", e_pend, 4'b0001);
        do_reset("t3_rst");

        // T4: new edge on bit1 coincides with ack of bit1.
        for (int k = 0; k < 3; k++) drive(4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 3; k++) drive(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
        drive(4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0);
        drive(4'b0010, 4'b0000, 1'b0, 2'd0, 1'b0);
        drive(4'b0010, 4'b0000, 1'b1, 2'd1, 1'b0);
        after_edge();
        chk("t4_collision", {e_pend, e_ovf}, {4'b0010, 4'b0000});
        do_reset("t4_rst");

        // T5: second edge while pending overflows; ovf_clr vs coincident overflow.
        for (int k = 0; k < 3; k++) drive(4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 3; k++) drive(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 3; k++) drive(4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0);
        after_edge();
        chk("t5_overflow", e_ovf, 4'b0001);
        drive(4'b0001, 4'b0000, 1'b0, 2'd0, 1'b1);
        after_edge();
        chk("t5_ovf_clr", e_ovf, 4'b0000);
        for (int k = 0; k < 3; k++) drive(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
        drive(4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0);
        drive(4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0);
        drive(4'b0001, 4'b0000, 1'b0, 2'd0, 1'b1);
        after_edge();
        chk("t5_ovf_wins", e_ovf, 4'b0001);
        do_reset("t5_rst");

        // T6: ack to a non-pending bit; level mode re-sets while line is held.
        drive(4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0);
        after_edge();
        chk("t6_ack_err", {e_pend, 3'b000, e_err}, {4'b0000, 4'b0001});
        drive(4'b1000, 4'b0000, 1'b0, 2'd0, 1'b0);
        after_edge();
        chk("t6_err_pulse", {3'b000, e_err}, 4'b0000);
        drive(4'b1000, 4'b0000, 1'b0, 2'd0, 1'b0);
        drive(4'b1000, 4'b0000, 1'b0, 2'd0, 1'b0);
        drive(4'b1000, 4'b0000, 1'b1, 2'd3, 1'b0);
        after_edge();
        chk("t6_level_hold", {l_pend, e_pend}, {4'b1000, 4'b0000});
        do_reset("t6_rst");

        // Randomised traffic with occasional mid-run resets.
        for (int n = 0; n < 600; n++) begin
            logic [3:0] flip;
            flip = '0;
            for (int i = 0; i < 4; i++) flip[i] = ($urandom_range(5) == 0);
            drive(req_in ^ flip, 4'($urandom), ($urandom_range(2) != 0),
                  2'($urandom), ($urandom_range(9) == 0));
            if (n == 300) do_reset("rnd_rst");
        end
        drive(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);

        begin
            int budget;
            budget = 0;
            while ((exp_q.size() > 0 || comb_q.size() > 0) && budget < 20) begin
                @(posedge clk);
                budget++;
            end
            #3;
            chk("sb_drain", exp_q.size() + comb_q.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
